// File: rtl/gate_checker_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gate_checker_if : stimulus/response bundle between gate_checker and the
//                   harness that wraps the two-input gate under test.
// Revision        : 1.0
// ----------------------------------------------------------------------------
interface gate_checker_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             y;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_valid;
  logic [1:0]       fail_vec;

  modport master (
    input  start, y,
    output a, b, busy, done, pass, err_cnt, fail_valid, fail_vec
  );

  modport slave (
    output start, y,
    input  a, b, busy, done, pass, err_cnt, fail_valid, fail_vec
  );
endinterface
`default_nettype wire

// File: rtl/gate_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gate_checker : sweeps a NOR cell through {A,B} = 00,01,10,11, compares Y with
//                ~(A|B), counts mismatches and records the first failing vector.
//                Macro GATE_CHECKER_STOP_ON_FAIL_EN ends a run at the first mismatch.
// Revision     : 1.0
// ----------------------------------------------------------------------------
module gate_checker #(
  parameter int SETTLE = 1,
  parameter int PASSES = 1,
  parameter int ERR_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  gate_checker_if.master bus
);

`ifdef GATE_CHECKER_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [15:0] PASS_LAST   = 16'(PASSES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [7:0]       settle_cnt;
  logic [1:0]       vec_cnt;
  logic [15:0]      pass_cnt;
  logic [ERR_W-1:0] err_cnt;
  logic             fail_valid;
  logic [1:0]       fail_vec;
  logic             mismatch;
  logic             last_vec;
  logic             last_pass;

  assign mismatch  = (state == ST_CHECK) && (bus.y != ~(vec_cnt[1] | vec_cnt[0]));
  assign last_vec  = (vec_cnt == 2'd3);
  assign last_pass = (pass_cnt == PASS_LAST);

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (settle_cnt == SETTLE_LAST) state_n = ST_CHECK;
      end
      ST_CHECK: begin
        if ((STOP_ON_FAIL && mismatch) || (last_vec && last_pass)) state_n = ST_DONE;
        else                                                       state_n = ST_WAIT;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      settle_cnt <= '0;
      vec_cnt    <= '0;
      pass_cnt   <= '0;
      err_cnt    <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            settle_cnt <= '0;
            vec_cnt    <= '0;
            pass_cnt   <= '0;
            err_cnt    <= '0;
            fail_valid <= 1'b0;
            fail_vec   <= '0;
          end
        end
        ST_WAIT: begin
          settle_cnt <= (settle_cnt == SETTLE_LAST) ? 8'd0 : settle_cnt + 8'd1;
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (err_cnt != {ERR_W{1'b1}}) err_cnt <= err_cnt + ERR_W'(1);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_vec   <= vec_cnt;
            end
          end
          // {A,B} is the vector counter itself, so parking it at 00 keeps A=B=0 in DONE.
          vec_cnt <= (state_n == ST_DONE) ? 2'd0 : vec_cnt + 2'd1;
          if (last_vec) pass_cnt <= pass_cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.a          = vec_cnt[1];
  assign bus.b          = vec_cnt[0];
  assign bus.busy       = (state == ST_WAIT) || (state == ST_CHECK);
  assign bus.done       = (state == ST_DONE);
  assign bus.pass       = (state == ST_DONE) && (err_cnt == '0);
  assign bus.err_cnt    = err_cnt;
  assign bus.fail_valid = fail_valid;
  assign bus.fail_vec   = fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_gate_checker.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gate_checker : bench for gate_checker with three parameter sets
//                   (SETTLE/PASSES = 1/1, 3/1, 1/70) and a NOR with fault masks.
// Revision        : 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gate_checker;

`ifdef GATE_CHECKER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  localparam int SAT = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] mask0 = 4'd0;
  logic [3:0] mask1 = 4'd0;
  logic [3:0] mask2 = 4'd0;
  int         checks = 0;
  int         errors = 0;
  int         sel = 0;
  logic [15:0] obs0, obs1, obs2, obs;

  always #5 clk = ~clk;

  gate_checker_if #(.ERR_W(8)) if0 ();
  gate_checker_if #(.ERR_W(8)) if1 ();
  gate_checker_if #(.ERR_W(8)) if2 ();

  gate_checker #(.SETTLE(1), .PASSES(1),  .ERR_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0.master));
  gate_checker #(.SETTLE(3), .PASSES(1),  .ERR_W(8)) dut1 (.clk(clk), .rst(rst), .bus(if1.master));
  gate_checker #(.SETTLE(1), .PASSES(70), .ERR_W(8)) dut2 (.clk(clk), .rst(rst), .bus(if2.master));

  // Gate under test: ideal NOR with Y inverted on every vector whose mask bit is set.
  assign if0.y = ~(if0.a | if0.b) ^ mask0[{if0.a, if0.b}];
  assign if1.y = ~(if1.a | if1.b) ^ mask1[{if1.a, if1.b}];
  assign if2.y = ~(if2.a | if2.b) ^ mask2[{if2.a, if2.b}];

  assign obs0 = {if0.busy, if0.done, if0.pass, if0.a, if0.b, if0.fail_valid, if0.fail_vec, if0.err_cnt};
  assign obs1 = {if1.busy, if1.done, if1.pass, if1.a, if1.b, if1.fail_valid, if1.fail_vec, if1.err_cnt};
  assign obs2 = {if2.busy, if2.done, if2.pass, if2.a, if2.b, if2.fail_valid, if2.fail_vec, if2.err_cnt};
  assign obs  = (sel == 0) ? obs0 : (sel == 1) ? obs1 : obs2;

  initial begin
    if0.start = 1'b0;
    if1.start = 1'b0;
    if2.start = 1'b0;
  end

  function automatic int settle_of(input int s);
    return (s == 1) ? 3 : 1;
  endfunction

  function automatic int passes_of(input int s);
    return (s == 2) ? 70 : 1;
  endfunction

  function automatic int first_fail(input logic [3:0] m);
    for (int i = 0; i < 4; i++) if (m[i]) return i;
    return 0;
  endfunction

  function automatic int vectors_in_run(input int passes, input logic [3:0] m);
    if (STOP && m != 4'd0) return first_fail(m) + 1;
    return 4 * passes;
  endfunction

  function automatic int raw_errors(input int n, input logic [3:0] m);
    int e = 0;
    for (int j = 0; j < n; j++) if (m[j % 4]) e++;
    return e;
  endfunction

  task automatic set_start(input int s, input logic v);
    case (s)
      0:       if0.start = v;
      1:       if1.start = v;
      default: if2.start = v;
    endcase
  endtask

  task automatic set_mask(input int s, input logic [3:0] m);
    case (s)
      0:       mask0 = m;
      1:       mask1 = m;
      default: mask2 = m;
    endcase
  endtask

  // One full run: START at an edge, then every cycle compared to the run model.
  // stray > 0 pulses START during that cycle of the run, which must be ignored.
  task automatic run_core(input int s, input logic [3:0] m, input int stray);
    int         per, nv, total, done_at, vi, nchk, raw, err_e;
    logic       busy_e, done_e, pass_e, fv_e;
    logic [1:0] ab_e, fvec_e;
    logic [4:0] exp_ctrl;
    logic [10:0] exp_stat;
    sel = s;
    set_mask(s, m);
    per   = settle_of(s) + 1;
    nv    = vectors_in_run(passes_of(s), m);
    total = nv * per;
    done_at = total + 1;
    @(negedge clk); set_start(s, 1'b1);
    @(negedge clk); set_start(s, 1'b0);
    for (int k = 1; k <= total + 2; k++) begin
      if (k == stray) set_start(s, 1'b1);
      busy_e = (k < done_at);
      done_e = !busy_e;
      vi     = busy_e ? ((k - 1) / per) % 4 : 0;
      ab_e   = 2'(vi);
      nchk   = (k - 1) / per;
      if (nchk > nv) nchk = nv;
      raw    = raw_errors(nchk, m);
      err_e  = (raw > SAT) ? SAT : raw;
      fv_e   = (raw > 0);
      fvec_e = fv_e ? 2'(first_fail(m)) : 2'd0;
      pass_e = done_e && (err_e == 0);
      exp_ctrl = {busy_e, done_e, pass_e, ab_e};
      exp_stat = {fv_e, fvec_e, 8'(err_e)};
      checks++;
      if (obs[15:11] !== exp_ctrl) begin
        errors++;
        $display("FAIL ctrl inst=%0d mask=%b cycle=%0d busy/done/pass/a/b got %b expected %b",
                 s, m, k, obs[15:11], exp_ctrl);
      end
      checks++;
      if (obs[10:0] !== exp_stat) begin
        errors++;
        $display("FAIL status inst=%0d mask=%b cycle=%0d fail_valid/fail_vec/err_cnt got %b expected %b",
                 s, m, k, obs[10:0], exp_stat);
      end
      @(negedge clk);
      if (k == stray) set_start(s, 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      checks++;
      if (obs !== 16'h0000) begin
        errors++;
        $display("FAIL reset_held inst=%0d outputs got %h expected 0000", s, obs);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      checks++;
      if (obs !== 16'h0000) begin
        errors++;
        $display("FAIL idle_after_reset inst=%0d outputs got %h expected 0000", s, obs);
      end
    end
  endtask

  task automatic test_ideal();
    run_core(0, 4'b0000, 0);
  endtask

  task automatic test_stuck0();
    run_core(0, 4'b0001, 0);
  endtask

  task automatic test_settle_ignored_start();
    run_core(1, 4'b0000, 5);
  endtask

  task automatic test_back_to_back();
    run_core(1, 4'b0100, 0);
    run_core(1, 4'b0000, 0);
  endtask

  task automatic test_saturation();
    run_core(2, 4'b1111, 0);
  endtask

  task automatic test_rst_midrun();
    sel = 0;
    set_mask(0, 4'b1110);
    @(negedge clk); set_start(0, 1'b1);
    @(negedge clk); set_start(0, 1'b0);
    repeat (3) @(negedge clk);
    checks++;
    if (obs[15:11] !== 5'b10001) begin
      errors++;
      $display("FAIL pre_rst busy/done/pass/a/b got %b expected 10001", obs[15:11]);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (obs !== 16'h0000) begin
      errors++;
      $display("FAIL rst_midrun outputs got %h expected 0000", obs);
    end
    rst = 1'b0;
    run_core(0, 4'b0000, 0);
  endtask

  task automatic test_random();
    int         s, stray;
    logic [3:0] m;
    for (int r = 0; r < 8; r++) begin
      s     = $urandom_range(0, 2);
      m     = 4'($urandom);
      stray = $urandom_range(0, 2);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_core(s, m, stray);
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_stuck0();
    test_settle_ignored_start();
    test_back_to_back();
    test_saturation();
    test_rst_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gate_checker.md
# gate_checker

Self-checking stimulus and response block for two-input gate cells. It drives the `A`/`B` inputs of a NOR cell under test through all four input vectors and reads back `Y`. It compares each `Y` against the expected value ~(A|B) and reports a pass/fail verdict, an error count and the first failing vector. It sits on the far side of the gate cell in gate-level test harnesses: the gate consumes `A`/`B` and produces `Y`, and this block produces `A`/`B` and consumes `Y`.

## Interface
- `SETTLE`, default 1: cycles `A`/`B` are held stable before `Y` is sampled; legal range 1..255.
- `PASSES`, default 1: number of full 4-vector sweeps per run; legal range 1..65535.
- `ERR_W`, default 8: width of the error counter.

Ports:
- `CLK` input 1: the single clock; all state updates on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `START` input 1: starts a run; sampled only in IDLE or DONE.
- `Y` input 1: output of the gate under test; treated as combinational from `A`/`B`.
- `A` output 1: gate input A, registered.
- `B` output 1: gate input B, registered.
- `BUSY` output 1: high while a run is in progress.
- `DONE` output 1: high from run completion until the next START or RST.
- `PASS` output 1: equals DONE && (ERR_CNT == 0).
- `ERR_CNT` output ERR_W: count of mismatches, saturating.
- `FAIL_VALID` output 1: at least one mismatch has been seen in this run.
- `FAIL_VEC` output 2: {A,B} of the first mismatch; valid only when FAIL_VALID is high.

## Operation
- States are IDLE, WAIT, CHECK and DONE.
- Reset values: state IDLE; A=0, B=0, BUSY=0, DONE=0, PASS=0, ERR_CNT=0, FAIL_VALID=0, FAIL_VEC=0. All internal counters reset to 0.
- IDLE or DONE with START=1 → WAIT. Before entering WAIT:
  - vector counter is set to 0 and {A,B}=00;
  - ERR_CNT, FAIL_VALID and FAIL_VEC are cleared;
  - pass counter is set to 0 and DONE drops.
- WAIT: the settle counter counts SETTLE cycles. On the last WAIT cycle the block goes to CHECK.
- CHECK lasts 1 cycle. At its closing edge:
  - Y is compared with ~(A|B);
  - on a mismatch, ERR_CNT increments, saturating at 2^ERR_W−1;
  - on a mismatch with FAIL_VALID=0, FAIL_VEC is set to {A,B} and FAIL_VALID is set to 1.
- After CHECK the vector counter advances in the order 00→01→10→11, and {A,B} is updated at the same edge.
- After vector 11 the counter wraps to 00 and the pass counter increments. When the pass counter reaches PASSES, the block goes to DONE; otherwise it goes to WAIT.
- DONE: BUSY=0, DONE=1, A=B=0. The state is held until START or RST.
- START while in WAIT or CHECK is ignored.
- RST has priority over START in the same cycle. RST during a run aborts it and all outputs return to their reset values at that edge.

## Timing
- START sampled at edge n → BUSY=1 and {A,B}=00 from cycle n+1.
- Each vector occupies SETTLE+1 cycles. A/B never change inside the window.
- A run takes 4·PASSES·(SETTLE+1) BUSY cycles. DONE rises the cycle after the last CHECK.
- ERR_CNT and FAIL_* update at the closing edge of CHECK, visible the next cycle.
- PASS is combinational from DONE and ERR_CNT, and has no extra latency.

## Configuration
- Macro: `GATE_CHECKER_STOP_ON_FAIL_EN`.
- Defined: a mismatch in CHECK moves the block directly to DONE at that edge. ERR_CNT=1, FAIL_VALID=1, A=B=0 and the remaining vectors and passes are skipped.
- Undefined: every vector of every pass is checked regardless of mismatches. FAIL_VEC still records only the first failure.

## Test plan
- Ideal NOR, SETTLE=1, PASSES=1, START at edge 0:
  - BUSY is high cycles 1–8;
  - {A,B}=00,01,10,11, each held 2 cycles;
  - DONE=1 and PASS=1 from cycle 9, ERR_CNT=0.
- Y stuck at 0, macro undefined: ERR_CNT=1, FAIL_VALID=1, FAIL_VEC=00, PASS=0, DONE at cycle 9.
- Y stuck at 0, macro defined: DONE at cycle 3, ERR_CNT=1, FAIL_VEC=00, BUSY low from cycle 3.
- Y = A|B, PASSES=70, ERR_W=8, macro undefined: 280 mismatches, so ERR_CNT saturates at 255; FAIL_VEC=00.
- SETTLE=3, ideal NOR: A/B held 4 cycles per vector and DONE at cycle 17. Then:
  - a START pulse at cycle 5 is ignored;
  - a START pulse in DONE restarts the run with DONE low the next cycle.
- Y stuck at 1, RST asserted at cycle 4 mid-run:
  - at cycle 5 all outputs are at reset values (ERR_CNT=0, FAIL_VALID=0, BUSY=0, A=B=0);
  - a subsequent START runs cleanly from vector 00.
